reg_uart_master: RTL and testbench
==================================

REG_UART_MASTER -- requirements
Module: reg_uart_master

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, meaning Regbus address width (1..32).
REQ-002 SHALL have parameter reg_req_t, default logic, meaning Regbus request type (addr, write, wdata[31:0], wstrb[3:0], valid).
REQ-003 SHALL have parameter reg_rsp_t, default logic, meaning Regbus response type (rdata[31:0], error, ready).
REQ-004 SHALL have parameter ClkDivide, default 868, meaning clk_i cycles per serial bit (>=4).
REQ-005 SHALL have parameter TimeoutCycles, default 1000000, meaning max idle cycles between bytes of one command.
REQ-006 SHALL have port clk_i  input  1  single clock.
REQ-007 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port reg_req_o  output  reg_req_t  Regbus master request.
REQ-009 SHALL have port reg_rsp_i  input  reg_rsp_t  Regbus response.
REQ-010 SHALL have port sin_i  input  1  serial RX, idle high.
REQ-011 SHALL have port sout_o  output  1  serial TX, idle high.
REQ-012 SHALL have port busy_o  output  1  high while a command is in progress (not IDLE).
REQ-013 SHALL have port err_o  output  1  one-cycle pulse on framing error, timeout or unknown command.

Function
REQ-014 Serial format SHALL be 8N1, LSB first, bit period ClkDivide cycles; sin_i double-flop synchronized.
REQ-015 RX SHALL detect start on synchronized falling edge, recheck low at half period, sample data bits at bit centers; stop bit 0 -> byte dropped, err_o pulse, FSM to IDLE.
REQ-016 Protocol: cmd byte 0x01 = write (4 addr bytes + 4 data bytes, LSB first); 0x02 = read (4 addr bytes).
REQ-017 FSM states SHALL be IDLE, ADDR, WDATA, REQ, RSP_STATUS, RSP_DATA; IDLE->ADDR on valid cmd; ADDR->WDATA (write) or REQ (read) after 4th byte; WDATA->REQ after 4th byte; REQ->RSP_STATUS on ready; RSP_STATUS->RSP_DATA (read) or IDLE (write); RSP_DATA->IDLE after 4th byte sent.
REQ-018 Unknown cmd byte SHALL transmit status 0xFF, pulse err_o, return to IDLE.
REQ-019 valid SHALL assert the cycle after the final command byte is accepted and hold, with addr/write/wdata stable, until the cycle ready is sampled high; wstrb SHALL be 4'hF for writes, 4'h0 for reads.
REQ-020 addr SHALL be the low AddrWidth bits of the received 32-bit address; upper bits discarded.
REQ-021 Status byte SHALL be 0x00 if error low, 0xEE if error high; read data (rdata captured at ready) SHALL follow status LSB first, 0x00000000 if error.
REQ-022 No timeout SHALL apply while in REQ (Regbus may stall indefinitely).
REQ-023 In ADDR/WDATA, TimeoutCycles cycles without a completed byte SHALL pulse err_o and return to IDLE with no Regbus access.
REQ-024 Bytes received in REQ/RSP_* SHALL be discarded.
REQ-025 TX byte SHALL start within 2 cycles of being scheduled; consecutive response bytes back-to-back (1 stop bit).

Reset
REQ-026 On rst_ni low: FSM IDLE, valid=0, write=0, addr/wdata/wstrb=0, sout_o=1, busy_o=0, err_o=0, counters/shift registers cleared.
REQ-027 Reset mid-transfer SHALL abort any in-progress serial byte and Regbus request with no further output activity.

Structure
REQ-028 Command codes (0x01, 0x02), status codes (0x00, 0xEE, 0xFF) and FSM state enum SHALL live in shared package reg_uart_master_pkg.
REQ-029 One sub-module reg_uart_master_phy SHALL implement 8N1 RX/TX (byte valid/ready handshakes, framing error flag); FSM and Regbus logic in top.

Verification
REQ-030 Write: serial 01 10 00 00 00 EF BE AD DE -> one request addr=0x10 write=1 wdata=0xDEADBEEF wstrb=F; ready -> TX 00.
REQ-031 Read: serial 02 04 00 00 00; responder rdata=0x12345678 after 5-cycle stall -> valid held 5 cycles, TX 00 78 56 34 12.
REQ-032 Error: read with error=1 -> TX EE 00 00 00 00; err_o stays low.
REQ-033 Bad cmd 0x55 -> TX FF, err_o pulse, no request; following valid read completes normally.
REQ-034 Timeout/framing: 3 addr bytes then silence TimeoutCycles -> err_o pulse, IDLE, no request; byte with stop=0 -> err_o pulse, dropped.
REQ-035 Reset asserted during WDATA -> sout_o=1, valid=0, busy_o=0 immediately; next command executes correctly.

Source files
------------

// File: rtl/reg_uart_master_pkg.sv
// Shared definitions for the serial-to-Regbus bridge: protocol command codes,
// response status codes, FSM states and default Regbus request/response types.
package reg_uart_master_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_READ    = 8'h02;

  localparam logic [7:0] STS_OK      = 8'h00;
  localparam logic [7:0] STS_BUS_ERR = 8'hEE;
  localparam logic [7:0] STS_BAD_CMD = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_REQ,
    ST_RSP_STATUS,
    ST_RSP_DATA
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_uart_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_uart_rsp_t;

endpackage

// File: rtl/reg_uart_master_phy.sv
// 8N1 serial PHY: LSB-first receiver with double-flop input synchronizer,
// start-bit recheck and framing check; transmitter accepts a new byte during
// the last cycle of the previous stop bit so response bytes run back-to-back.
module reg_uart_master_phy #(
  parameter int unsigned ClkDivide = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sin_i,
  output logic       sout_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o
);

  localparam int unsigned CntW = $clog2(ClkDivide + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(ClkDivide - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClkDivide / 2 - 1);

  logic            r_sin_s1, r_sin_s2, r_sin_d;
  logic            r_rx_busy;
  logic [CntW-1:0] r_rx_cnt;
  logic [3:0]      r_rx_idx;   // 0: start recheck, 1..8: data, 9: stop
  logic [7:0]      r_rx_shift;
  logic            r_rx_valid;
  logic            r_rx_ferr;

  logic            r_tx_busy;
  logic [CntW-1:0] r_tx_cnt;
  logic [3:0]      r_tx_idx;
  logic [9:0]      r_tx_shift; // {stop, data[7:0], start}, shifted out LSB first
  logic            w_tx_last;
  logic            w_tx_go;

  // Receiver: synchronize, find start edge, sample each bit at its center.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sin_s1   <= 1'b1;
      r_sin_s2   <= 1'b1;
      r_sin_d    <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_sin_s1   <= sin_i;
      r_sin_s2   <= r_sin_s1;
      r_sin_d    <= r_sin_s2;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      if (!r_rx_busy) begin
        if (r_sin_d && !r_sin_s2) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= '0;
          r_rx_idx  <= '0;
        end
      end else if (r_rx_idx == 4'd0) begin
        if (r_rx_cnt == CntHalf) begin
          r_rx_cnt <= '0;
          if (r_sin_s2) r_rx_busy <= 1'b0;  // glitch, not a real start bit
          else          r_rx_idx  <= 4'd1;
        end else begin
          r_rx_cnt <= r_rx_cnt + 1'b1;
        end
      end else if (r_rx_cnt == CntLast) begin
        r_rx_cnt <= '0;
        if (r_rx_idx == 4'd9) begin
          r_rx_busy <= 1'b0;
          if (r_sin_s2) r_rx_valid <= 1'b1;
          else          r_rx_ferr  <= 1'b1;
        end else begin
          r_rx_shift <= {r_sin_s2, r_rx_shift[7:1]};
          r_rx_idx   <= r_rx_idx + 1'b1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end
    end
  end

  assign w_tx_last = r_tx_busy && (r_tx_idx == 4'd9) && (r_tx_cnt == CntLast);
  assign w_tx_go   = tx_valid_i && tx_ready_o;

  // Transmitter: load a 10-bit frame and shift it out one bit period at a time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_busy  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '1;
    end else if (w_tx_go) begin
      r_tx_busy  <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= {1'b1, tx_data_i, 1'b0};
    end else if (r_tx_busy) begin
      if (r_tx_cnt == CntLast) begin
        r_tx_cnt <= '0;
        if (r_tx_idx == 4'd9) begin
          r_tx_busy <= 1'b0;
        end else begin
          r_tx_idx   <= r_tx_idx + 1'b1;
          r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  assign tx_ready_o     = !r_tx_busy || w_tx_last;
  assign sout_o         = r_tx_busy ? r_tx_shift[0] : 1'b1;
  assign rx_data_o      = r_rx_shift;
  assign rx_valid_o     = r_rx_valid;
  assign rx_frame_err_o = r_rx_ferr;

endmodule

// File: rtl/reg_uart_master.sv
// Serial command bridge to Regbus: decodes write/read commands arriving over
// 8N1 serial, issues one Regbus access and streams back status (and read data).
module reg_uart_master
  import reg_uart_master_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter type         reg_req_t     = reg_uart_req_t,
  parameter type         reg_rsp_t     = reg_uart_rsp_t,
  parameter int unsigned ClkDivide     = 868,
  parameter int unsigned TimeoutCycles = 1000000
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i,
  input  logic     sin_i,
  output logic     sout_o,
  output logic     busy_o,
  output logic     err_o
);

  localparam logic [31:0] AddrMask = (AddrWidth >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << AddrWidth) - 32'd1);
  localparam logic [31:0] ToLast   = 32'(TimeoutCycles - 1);

  state_e      r_state, w_next;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_addr, r_wdata, r_rdata, r_to_cnt;
  logic [7:0]  r_status;
  logic        r_write, r_err;

  logic [7:0]  w_rx_data, w_tx_data;
  logic        w_rx_valid, w_rx_ferr, w_tx_valid, w_tx_ready;
  logic        w_err, w_timeout, w_tx_go;

  reg_uart_master_phy #(
    .ClkDivide (ClkDivide)
  ) u_phy (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sin_i          (sin_i),
    .sout_o         (sout_o),
    .tx_data_i      (w_tx_data),
    .tx_valid_i     (w_tx_valid),
    .tx_ready_o     (w_tx_ready),
    .rx_data_o      (w_rx_data),
    .rx_valid_o     (w_rx_valid),
    .rx_frame_err_o (w_rx_ferr)
  );

  assign w_timeout = (r_to_cnt == ToLast);
  assign w_tx_go   = w_tx_valid && w_tx_ready;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode plus TX byte selection and error strobe.
  always_comb begin
    w_next     = r_state;
    w_tx_valid = 1'b0;
    w_tx_data  = r_status;
    w_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_valid) begin
          if (w_rx_data == CMD_WRITE || w_rx_data == CMD_READ) begin
            w_next = ST_ADDR;
          end else begin
            w_next = ST_RSP_STATUS;
            w_err  = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (w_rx_valid && r_byte_cnt == 2'd3) begin
          w_next = r_write ? ST_WDATA : ST_REQ;
        end else if (!w_rx_valid && w_timeout) begin
          w_next = ST_IDLE;
          w_err  = 1'b1;
        end
      end
      ST_WDATA: begin
        if (w_rx_valid && r_byte_cnt == 2'd3) begin
          w_next = ST_REQ;
        end else if (!w_rx_valid && w_timeout) begin
          w_next = ST_IDLE;
          w_err  = 1'b1;
        end
      end
      ST_REQ: begin
        if (reg_rsp_i.ready) w_next = ST_RSP_STATUS;
      end
      ST_RSP_STATUS: begin
        w_tx_valid = 1'b1;
        if (w_tx_ready) begin
          w_next = (r_status != STS_BAD_CMD && !r_write) ? ST_RSP_DATA : ST_IDLE;
        end
      end
      ST_RSP_DATA: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_rdata[7:0];
        if (w_tx_ready && r_byte_cnt == 2'd3) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // A corrupted byte aborts command reception; responses already underway finish.
    if (w_rx_ferr) begin
      w_err = 1'b1;
      if (r_state == ST_IDLE || r_state == ST_ADDR || r_state == ST_WDATA) w_next = ST_IDLE;
    end
  end

  // Command datapath: byte counting, address/data assembly, response capture, timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_byte_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_status   <= '0;
      r_write    <= 1'b0;
      r_to_cnt   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err;

      if (r_state != w_next) begin
        r_byte_cnt <= '0;
      end else if (((r_state == ST_ADDR || r_state == ST_WDATA) && w_rx_valid) ||
                   (r_state == ST_RSP_DATA && w_tx_go)) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end

      if ((r_state == ST_ADDR || r_state == ST_WDATA) && !w_rx_valid && r_state == w_next) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end

      if (r_state == ST_IDLE && w_rx_valid) begin
        if (w_rx_data == CMD_WRITE)     r_write  <= 1'b1;
        else if (w_rx_data == CMD_READ) r_write  <= 1'b0;
        else                            r_status <= STS_BAD_CMD;
      end

      if (r_state == ST_ADDR && w_rx_valid)  r_addr  <= {w_rx_data, r_addr[31:8]};
      if (r_state == ST_WDATA && w_rx_valid) r_wdata <= {w_rx_data, r_wdata[31:8]};

      if (r_state == ST_REQ && reg_rsp_i.ready) begin
        r_status <= reg_rsp_i.error ? STS_BUS_ERR : STS_OK;
        r_rdata  <= reg_rsp_i.error ? 32'h0 : reg_rsp_i.rdata;
      end else if (r_state == ST_RSP_DATA && w_tx_go) begin
        r_rdata <= {8'h00, r_rdata[31:8]};
      end
    end
  end

  // Regbus request: held stable from the registers for the whole REQ state.
  always_comb begin
    reg_req_o       = '0;
    reg_req_o.addr  = r_addr & AddrMask;
    reg_req_o.write = r_write;
    reg_req_o.wdata = r_wdata;
    reg_req_o.wstrb = r_write ? 4'hF : 4'h0;
    reg_req_o.valid = (r_state == ST_REQ);
  end

  assign busy_o = (r_state != ST_IDLE);
  assign err_o  = r_err;

endmodule

// File: tb/tb_reg_uart_master.sv
// Directed bench for reg_uart_master: serial driver, serial response
// receiver, stalling Regbus responder, and immediate-assertion checks.
module tb_reg_uart_master;
  import reg_uart_master_pkg::*;

  localparam int CD = 8;
  localparam int TO = 200;

  logic          clk;
  logic          rst_n;
  logic          sin;
  logic          sout;
  logic          busy;
  logic          err;
  reg_uart_req_t req;
  reg_uart_rsp_t rsp;

  int tests = 0;
  int fails = 0;

  logic [7:0]  rxq[$];
  int          nreq = 0;
  logic [31:0] log_addr, log_wdata;
  logic        log_write;
  logic [3:0]  log_wstrb;
  int          last_stall = 0;
  int          unstable = 0;
  int          err_cnt = 0;

  int          cfg_stall = 0;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_err = 1'b0;

  reg_uart_master #(
    .AddrWidth     (32),
    .ClkDivide     (CD),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .reg_req_o (req),
    .reg_rsp_i (rsp),
    .sin_i     (sin),
    .sout_o    (sout),
    .busy_o    (busy),
    .err_o     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] getb(input int i);
    if (i < rxq.size()) return rxq[i];
    return 8'hxx;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    sin = 1'b0;
    repeat (CD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sin = b[i];
      repeat (CD) @(negedge clk);
    end
    sin = stop_ok;
    repeat (CD) @(negedge clk);
    sin = 1'b1;
    if (!stop_ok) repeat (CD) @(negedge clk);
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int k = 0;
    while (rxq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, rxq.size(), n);
  endtask

  // Serial receiver for the DUT's response bytes.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge sout);
      repeat (CD / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CD) @(negedge clk);
        b[i] = sout;
      end
      repeat (CD) @(negedge clk);
      rxq.push_back(b);
    end
  end

  // Regbus responder with configurable stall, logging each accepted request.
  initial begin
    int          stall_cnt = 0;
    logic [31:0] snap_addr, snap_wdata;
    logic        snap_write;
    rsp = '0;
    forever begin
      @(negedge clk);
      if (req.valid && !rsp.ready) begin
        if (stall_cnt == 0) begin
          snap_addr  = req.addr;
          snap_wdata = req.wdata;
          snap_write = req.write;
        end else if (req.addr !== snap_addr || req.wdata !== snap_wdata ||
                     req.write !== snap_write) begin
          unstable++;
        end
        if (stall_cnt == cfg_stall) begin
          rsp.ready  = 1'b1;
          rsp.rdata  = cfg_rdata;
          rsp.error  = cfg_err;
          log_addr   = req.addr;
          log_write  = req.write;
          log_wdata  = req.wdata;
          log_wstrb  = req.wstrb;
          last_stall = stall_cnt;
          nreq++;
          stall_cnt  = 0;
        end else begin
          stall_cnt++;
        end
      end else begin
        rsp = '0;
        if (!req.valid) stall_cnt = 0;
      end
    end
  end

  // Count err_o pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (err === 1'b1) err_cnt++;
    end
  end

  initial begin
    int e0, n0;
    sin   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sout", sout, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_valid", req.valid, 0);
    check("rst_write", req.write, 0);
    check("rst_wstrb", req.wstrb, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write 0xDEADBEEF to 0x10
    rxq.delete();
    send_byte(8'h01, 1); send_byte(8'h10, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    send_byte(8'h00, 1); send_byte(8'hEF, 1); send_byte(8'hBE, 1); send_byte(8'hAD, 1);
    send_byte(8'hDE, 1);
    wait_rx("wr_rx_count", 1, 400);
    check("wr_nreq", nreq, 1);
    check("wr_addr", log_addr, 32'h10);
    check("wr_write", log_write, 1);
    check("wr_wdata", log_wdata, 32'hDEADBEEF);
    check("wr_wstrb", log_wstrb, 4'hF);
    check("wr_status", getb(0), 8'h00);
    repeat (20) @(negedge clk);
    check("wr_idle", busy, 0);

    // Read 0x04 with 5-cycle stall
    rxq.delete();
    cfg_stall = 5; cfg_rdata = 32'h12345678; cfg_err = 1'b0;
    send_byte(8'h02, 1); send_byte(8'h04, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    wait_rx("rd_rx_count", 5, 1200);
    check("rd_nreq", nreq, 2);
    check("rd_addr", log_addr, 32'h04);
    check("rd_write", log_write, 0);
    check("rd_wstrb", log_wstrb, 4'h0);
    check("rd_stall", last_stall, 5);
    check("rd_stable", unstable, 0);
    check("rd_b0", getb(0), 8'h00);
    check("rd_b1", getb(1), 8'h78);
    check("rd_b2", getb(2), 8'h56);
    check("rd_b3", getb(3), 8'h34);
    check("rd_b4", getb(4), 8'h12);

    // Read with bus error
    rxq.delete();
    e0 = err_cnt;
    cfg_stall = 0; cfg_rdata = 32'hFFFFFFFF; cfg_err = 1'b1;
    send_byte(8'h02, 1); send_byte(8'h08, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    wait_rx("er_rx_count", 5, 1200);
    check("er_b0", getb(0), 8'hEE);
    check("er_b1", getb(1), 8'h00);
    check("er_b2", getb(2), 8'h00);
    check("er_b3", getb(3), 8'h00);
    check("er_b4", getb(4), 8'h00);
    check("er_no_err", err_cnt, e0);
    cfg_err = 1'b0;

    // Unknown command, then a normal read
    rxq.delete();
    e0 = err_cnt; n0 = nreq;
    send_byte(8'h55, 1);
    wait_rx("bad_rx_count", 1, 400);
    check("bad_status", getb(0), 8'hFF);
    check("bad_err", err_cnt, e0 + 1);
    check("bad_noreq", nreq, n0);
    repeat (20) @(negedge clk);
    rxq.delete();
    cfg_rdata = 32'hCAFEF00D;
    send_byte(8'h02, 1); send_byte(8'h20, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    wait_rx("bad2_rx_count", 5, 1200);
    check("bad2_nreq", nreq, n0 + 1);
    check("bad2_addr", log_addr, 32'h0120);
    check("bad2_b0", getb(0), 8'h00);
    check("bad2_b1", getb(1), 8'h0D);
    check("bad2_b4", getb(4), 8'hCA);
    repeat (20) @(negedge clk);

    // Timeout after 3 address bytes
    rxq.delete();
    e0 = err_cnt; n0 = nreq;
    send_byte(8'h02, 1); send_byte(8'h04, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    check("to_busy_before", busy, 1);
    repeat (TO + 50) @(negedge clk);
    check("to_err", err_cnt, e0 + 1);
    check("to_idle", busy, 0);
    check("to_noreq", nreq, n0);
    check("to_no_tx", rxq.size(), 0);

    // Framing error
    e0 = err_cnt;
    send_byte(8'hA5, 0);
    repeat (20) @(negedge clk);
    check("fr_err", err_cnt, e0 + 1);
    check("fr_idle", busy, 0);
    check("fr_no_tx", rxq.size(), 0);

    // Reset in the middle of WDATA
    n0 = nreq;
    send_byte(8'h01, 1); send_byte(8'h10, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    send_byte(8'h00, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
    check("rs_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rs_sout", sout, 1);
    check("rs_valid", req.valid, 0);
    check("rs_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rxq.delete();
    send_byte(8'h01, 1); send_byte(8'h20, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    send_byte(8'h00, 1); send_byte(8'h44, 1); send_byte(8'h33, 1); send_byte(8'h22, 1);
    send_byte(8'h11, 1);
    wait_rx("rs_rx_count", 1, 400);
    check("rs_nreq", nreq, n0 + 1);
    check("rs_addr", log_addr, 32'h20);
    check("rs_wdata", log_wdata, 32'h11223344);
    check("rs_status", getb(0), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
